// File: rtl/av_ram_burst_pkg.sv
// av_ram_burst_pkg: shared response codes and FSM state encoding for the burst RAM slave.
package av_ram_burst_pkg;

    localparam logic [1:0] AV_RSP_OKAY   = 2'b00;
    localparam logic [1:0] AV_RSP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        AV_ST_IDLE,
        AV_ST_WR,
        AV_ST_RD
    } st_t;

endpackage

// File: rtl/av_ram_burst_if.sv
// av_ram_burst_if: Avalon-MM bursting bus bundle between interconnect master and RAM slave.
interface av_ram_burst_if #(
    parameter int dw  = 32,
    parameter int aw  = 10,
    parameter int bcw = 4
) ();

    logic [aw-1:0]   av_address_i;
    logic [dw-1:0]   av_writedata_i;
    logic [dw/8-1:0] av_byteenable_i;
    logic [bcw-1:0]  av_burstcount_i;
    logic            av_write_i;
    logic            av_read_i;
    logic            av_waitrequest_o;
    logic            av_readdatavalid_o;
    logic [1:0]      av_response_o;
    logic [dw-1:0]   av_readdata_o;

    modport master (
        output av_address_i, av_writedata_i, av_byteenable_i, av_burstcount_i, av_write_i, av_read_i,
        input  av_waitrequest_o, av_readdatavalid_o, av_response_o, av_readdata_o
    );

    modport slave (
        input  av_address_i, av_writedata_i, av_byteenable_i, av_burstcount_i, av_write_i, av_read_i,
        output av_waitrequest_o, av_readdatavalid_o, av_response_o, av_readdata_o
    );

endinterface

// File: rtl/av_ram_dp_be.sv
// av_ram_dp_be: simple dual-port synchronous RAM, byte-enable write port, 1-cycle registered read port.
module av_ram_dp_be #(
    parameter int dw      = 32,
    parameter int depth   = 1024,
    parameter int aw      = $clog2(depth),
    parameter     memfile = ""
) (
    input  logic            clk,
    input  logic            we,
    input  logic [dw/8-1:0] be,
    input  logic [aw-1:0]   waddr,
    input  logic [dw-1:0]   wdata,
    input  logic [aw-1:0]   raddr,
    output logic [dw-1:0]   rdata
);

    logic [dw-1:0] mem [depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < dw/8; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/av_ram_burst.sv
// av_ram_burst: Avalon-MM burst slave RAM, one command in flight, pipelined reads via readdatavalid.
// Define AV_RAM_BURST_RANGE_CHK_EN to flag bursts running past depth (SLAVEERROR, no writes, zero read data).
module av_ram_burst
    import av_ram_burst_pkg::*;
#(
    parameter int dw      = 32,
    parameter int depth   = 1024,
    parameter int aw      = $clog2(depth),
    parameter int bcw     = 4,
    parameter     memfile = ""
) (
    input  logic         av_clk_i,
    input  logic         av_rst_n_i,
    av_ram_burst_if.slave av
);

    st_t            st;
    logic [aw-1:0]  addr_q;
    logic [bcw-1:0] cnt_q;
    logic           wait_q;
    logic           rdv_q;
    logic           err_q;
    logic [bcw-1:0] bc_eff;
    logic [aw-1:0]  cur_addr;
    logic           acc_err;
    logic           cur_err;
    logic           idle_wr;
    logic           idle_rd;
    logic           we;
    logic           conflict;
    logic [dw-1:0]  q;

    function automatic logic [aw-1:0] inc(input logic [aw-1:0] a);
        return (32'(a) == depth - 1) ? '0 : a + aw'(1);
    endfunction

    assign bc_eff   = (av.av_burstcount_i == '0) ? bcw'(1) : av.av_burstcount_i;
    assign idle_wr  = st == AV_ST_IDLE && !wait_q && av.av_write_i;
    assign idle_rd  = st == AV_ST_IDLE && !wait_q && av.av_read_i && !av.av_write_i;
    assign conflict = st == AV_ST_IDLE && !wait_q && av.av_write_i && av.av_read_i;
    assign we       = idle_wr || (st == AV_ST_WR && av.av_write_i);
    assign cur_addr = (st == AV_ST_IDLE) ? av.av_address_i : addr_q;
    assign cur_err  = (st == AV_ST_IDLE) ? acc_err : err_q;

`ifdef AV_RAM_BURST_RANGE_CHK_EN
    assign acc_err = int'(av.av_address_i) + int'(bc_eff) > depth;
`else
    assign acc_err = 1'b0;
`endif

    av_ram_dp_be #(.dw(dw), .depth(depth), .aw(aw), .memfile(memfile)) u_ram (
        .clk   (av_clk_i),
        .we    (we && !cur_err),
        .be    (av.av_byteenable_i),
        .waddr (cur_addr),
        .wdata (av.av_writedata_i),
        .raddr (cur_addr),
        .rdata (q)
    );

    assign av.av_waitrequest_o   = wait_q;
    assign av.av_readdatavalid_o = rdv_q;
    assign av.av_readdata_o      = (rdv_q && !err_q) ? q : '0;
    assign av.av_response_o      = (rdv_q ? err_q : we && cur_err) ? AV_RSP_SLVERR : AV_RSP_OKAY;

    // cnt_q counts beats whose address has not yet been presented to the RAM
    always_ff @(posedge av_clk_i or negedge av_rst_n_i) begin
        if (!av_rst_n_i) begin
            st     <= AV_ST_IDLE;
            addr_q <= '0;
            cnt_q  <= '0;
            wait_q <= 1'b1;
            rdv_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= 1'b0;
            rdv_q  <= 1'b0;
            case (st)
                AV_ST_IDLE: begin
                    if (idle_wr) begin
                        addr_q <= inc(av.av_address_i);
                        cnt_q  <= bc_eff - bcw'(1);
                        err_q  <= acc_err;
                        st     <= (bc_eff == bcw'(1)) ? AV_ST_IDLE : AV_ST_WR;
                    end else if (idle_rd) begin
                        addr_q <= inc(av.av_address_i);
                        cnt_q  <= bc_eff - bcw'(1);
                        err_q  <= acc_err;
                        rdv_q  <= 1'b1;
                        wait_q <= 1'b1;
                        st     <= AV_ST_RD;
                    end
                end
                AV_ST_WR: begin
                    if (av.av_write_i) begin
                        addr_q <= inc(addr_q);
                        cnt_q  <= cnt_q - bcw'(1);
                        if (cnt_q == bcw'(1)) st <= AV_ST_IDLE;
                    end
                end
                AV_ST_RD: begin
                    if (cnt_q != '0) begin
                        addr_q <= inc(addr_q);
                        cnt_q  <= cnt_q - bcw'(1);
                        rdv_q  <= 1'b1;
                        wait_q <= 1'b1;
                    end else begin
                        st <= AV_ST_IDLE;
                    end
                end
                default: st <= AV_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge av_clk_i)
        assert (!conflict) else $warning("av_ram_burst: read and write asserted together, read dropped");

endmodule

// File: tb/tb_av_ram_burst.sv
// tb_av_ram_burst: table vectors, directed corner sequences and random bursts against a word-array model.
module tb_av_ram_burst;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int BCW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    av_ram_burst_if #(.dw(DW), .aw(AW), .bcw(BCW)) av ();

    av_ram_burst #(.dw(DW), .depth(DEPTH), .aw(AW), .bcw(BCW), .memfile("")) dut (
        .av_clk_i   (clk),
        .av_rst_n_i (rst_n),
        .av         (av)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] wbuf [8];
    logic [3:0]  bebuf [8];
    logic [31:0] last_rd;

    typedef struct {
        int          addr;
        logic [31:0] first;
        logic [3:0]  be;
        logic [31:0] second;
        logic [31:0] expd;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbeats(input int bc);
        return bc == 0 ? 1 : bc;
    endfunction

    function automatic bit range_err(input int a, input int bc);
`ifdef AV_RAM_BURST_RANGE_CHK_EN
        return a + nbeats(bc) > DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (av.av_waitrequest_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (av.av_waitrequest_o) chk("ready_timeout", 64'(av.av_waitrequest_o), 64'd0);
    endtask

    task automatic wr_burst(input int a, input int bc, input int gap_at, input bit with_read);
        int n = nbeats(bc);
        bit e = range_err(a, bc);
        wait_ready();
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                av.av_write_i = 1'b0;
                @(negedge clk);
            end
            av.av_address_i    = AW'(a);
            av.av_burstcount_i = BCW'(bc);
            av.av_writedata_i  = wbuf[k];
            av.av_byteenable_i = bebuf[k];
            av.av_write_i      = 1'b1;
            av.av_read_i       = with_read && k == 0;
            #1 chk("wr_rsp", 64'(av.av_response_o), e ? 64'd2 : 64'd0);
            @(negedge clk);
            if (!e)
                for (int b = 0; b < 4; b++)
                    if (bebuf[k][b]) mdl[(a + k) % DEPTH][8*b +: 8] = wbuf[k][8*b +: 8];
        end
        av.av_write_i = 1'b0;
        av.av_read_i  = 1'b0;
    endtask

    task automatic rd_burst(input int a, input int bc);
        int n = nbeats(bc);
        bit e = range_err(a, bc);
        wait_ready();
        av.av_address_i    = AW'(a);
        av.av_burstcount_i = BCW'(bc);
        av.av_read_i       = 1'b1;
        @(negedge clk);
        av.av_read_i       = 1'b0;
        av.av_address_i    = AW'($urandom);
        av.av_burstcount_i = BCW'($urandom);
        for (int k = 0; k < n; k++) begin
            chk("rd_valid", 64'(av.av_readdatavalid_o), 64'd1);
            chk("rd_data", 64'(av.av_readdata_o), e ? 64'd0 : 64'(mdl[(a + k) % DEPTH]));
            chk("rd_rsp", 64'(av.av_response_o), e ? 64'd2 : 64'd0);
            chk("rd_wait", 64'(av.av_waitrequest_o), 64'd1);
            last_rd = av.av_readdata_o;
            @(negedge clk);
        end
        chk("rd_end_valid", 64'(av.av_readdatavalid_o), 64'd0);
        chk("rd_end_wait", 64'(av.av_waitrequest_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vt[0] = '{2, 32'hFFFFFFFF, 4'b0101, 32'h00000000, 32'hFF00FF00};
        vt[1] = '{3, 32'h00000000, 4'b1010, 32'hAABBCCDD, 32'hAA00CC00};
        vt[2] = '{4, 32'h12345678, 4'b0000, 32'hFFFFFFFF, 32'h12345678};
        vt[3] = '{5, 32'h00000000, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[4] = '{6, 32'h11111111, 4'b1000, 32'h22222222, 32'h22111111};

        av.av_address_i    = '0;
        av.av_writedata_i  = '0;
        av.av_byteenable_i = '0;
        av.av_burstcount_i = '0;
        av.av_write_i      = 1'b0;
        av.av_read_i       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_wait", 64'(av.av_waitrequest_o), 64'd1);
        chk("rst_rdv", 64'(av.av_readdatavalid_o), 64'd0);
        chk("rst_rsp", 64'(av.av_response_o), 64'd0);
        chk("rst_rdata", 64'(av.av_readdata_o), 64'd0);
        rst_n = 1'b1;
        #1 chk("release_wait_hold", 64'(av.av_waitrequest_o), 64'd1);
        @(negedge clk);
        chk("release_wait_drop", 64'(av.av_waitrequest_o), 64'd0);

        // fill the whole array so every later read has a known expectation
        for (int blk = 0; blk < DEPTH / 8; blk++) begin
            for (int k = 0; k < 8; k++) begin
                wbuf[k]  = $urandom;
                bebuf[k] = 4'hF;
            end
            wr_burst(blk * 8, 8, -1, 1'b0);
        end

        for (int i = 0; i < 5; i++) begin
            wbuf[0] = vt[i].first;  bebuf[0] = 4'hF;
            wr_burst(vt[i].addr, 1, -1, 1'b0);
            wbuf[0] = vt[i].second; bebuf[0] = vt[i].be;
            wr_burst(vt[i].addr, 1, -1, 1'b0);
            rd_burst(vt[i].addr, 1);
            chk("tbl_data", 64'(last_rd), 64'(vt[i].expd));
        end

        for (int k = 0; k < 4; k++) begin
            wbuf[k]  = 32'(k + 1);
            bebuf[k] = 4'hF;
        end
        wr_burst(8, 4, 2, 1'b0);
        rd_burst(8, 4);
        chk("gap_last", 64'(last_rd), 64'd4);

        for (int k = 0; k < 3; k++) begin
            wbuf[k]  = 32'hA0A0_0000 + 32'(k);
            bebuf[k] = 4'hF;
        end
        wr_burst(1023, 3, -1, 1'b0);
        rd_burst(1023, 1);
        rd_burst(0, 1);
        rd_burst(1, 1);
        rd_burst(1022, 4);

        wait_ready();
        av.av_address_i    = AW'(100);
        av.av_burstcount_i = BCW'(8);
        av.av_read_i       = 1'b1;
        @(negedge clk);
        av.av_read_i = 1'b0;
        @(negedge clk);
        chk("mid_rd_beat1", 64'(av.av_readdatavalid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_rdv", 64'(av.av_readdatavalid_o), 64'd0);
        chk("mid_rst_wait", 64'(av.av_waitrequest_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_still_idle", 64'(av.av_readdatavalid_o), 64'd0);
        rst_n = 1'b1;
        rd_burst(100, 8);

        rd_burst(300, 0);
        wbuf[0] = 32'h5A5A_1234; bebuf[0] = 4'hF;
        wr_burst(301, 0, -1, 1'b0);
        rd_burst(300, 2);

        wbuf[0] = 32'hCAFEF00D; bebuf[0] = 4'hF;
        wr_burst(200, 1, -1, 1'b1);
        chk("conflict_no_rdv", 64'(av.av_readdatavalid_o), 64'd0);
        chk("conflict_no_wait", 64'(av.av_waitrequest_o), 64'd0);
        rd_burst(200, 1);
        chk("conflict_data", 64'(last_rd), 64'hCAFEF00D);

        for (int it = 0; it < 60; it++) begin
            int a  = int'($urandom_range(0, DEPTH - 1));
            int bc = int'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    wbuf[k]  = $urandom;
                    bebuf[k] = 4'($urandom);
                end
                wr_burst(a, bc, int'($urandom_range(0, 9)), 1'b0);
            end else begin
                rd_burst(a, bc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
